// File: rtl/reprodutor_sequencia_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkg_notas
// Description : Shared types and constants for the note-sequence player.
//               Defines the playback state encoding and the widths of the
//               note, index, bank and memory-address fields.
// Revision    : 1.0 - initial release
// ============================================================================
package pkg_notas;

   localparam int LARGURA_NOTA      = 3;
   localparam int LARGURA_ENDERECO  = 6;
   localparam int NOTAS_POR_DESAFIO = 16;

   // Address splits into {bank, index}; index covers one bank exactly.
   localparam int LARGURA_INDICE    = $clog2(NOTAS_POR_DESAFIO);
   localparam int LARGURA_DESAFIO   = LARGURA_ENDERECO - LARGURA_INDICE;

   typedef enum logic [2:0] {
      OCIOSO  = 3'd0,
      CARREGA = 3'd1,
      TOCA    = 3'd2,
      PAUSA   = 3'd3,
      FIM     = 3'd4
   } estado_t;

endpackage
`default_nettype wire

// File: rtl/reprodutor_sequencia_temporizador_nota.sv
`default_nettype none
// ============================================================================
// Module      : temporizador_nota
// Description : Up-counter producing a one-cycle pulse after `limit` enabled
//               cycles. The count returns to zero on that pulse, so the
//               same instance can be reused back to back with a new limit.
// Ports       : clock     - system clock
//               reset     - asynchronous active-high reset
//               clear     - synchronous count clear
//               enable    - count this cycle
//               limit     - number of enabled cycles per period (>= 1)
//               fim_tempo - high in the cycle where count == limit-1
// Revision    : 1.0 - initial release
// ============================================================================
module temporizador_nota #(
   parameter int LARGURA = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               enable,
   input  logic [LARGURA-1:0] limit,
   output logic               fim_tempo
);

   logic [LARGURA-1:0] r_contagem;
   logic               w_no_limite;

   // Compared against limit-1 so the count never needs to reach limit.
   assign w_no_limite = (r_contagem == (limit - LARGURA'(1)));
   assign fim_tempo   = enable & w_no_limite;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_contagem <= '0;
      end else if (clear || fim_tempo) begin
         r_contagem <= '0;
      end else if (enable) begin
         r_contagem <= r_contagem + LARGURA'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/reprodutor_sequencia.sv
`default_nettype none
// ============================================================================
// Module      : reprodutor_sequencia
// Description : Plays one challenge sequence from the note memory. Walks the
//               16-note bank chosen by `desafio` from index 0 to `rodada`;
//               each note is loaded (1 cycle), sounded for T_NOTA cycles and
//               followed by T_PAUSA silent cycles. A one-cycle
//               `fim_reproducao` pulse closes a complete playback.
// Ports       : clock          - system clock, rising edge
//               reset          - asynchronous active-high reset
//               iniciar        - start request (idle only)
//               parar          - abort to idle, beats everything but reset
//               desafio[1:0]   - bank select, latched at start
//               rodada[3:0]    - last index to play, latched at start
//               nota_mem[2:0]  - memory data for `endereco` (async read)
//               endereco[5:0]  - memory address {bank, index}
//               nota_saida[2:0]- registered current note
//               nota_valida    - note is sounding
//               ocupado        - any state other than idle
//               fim_reproducao - one-cycle end-of-playback pulse
// Revision    : 1.0 - initial release
// ============================================================================
module reprodutor_sequencia
   import pkg_notas::*;
#(
   parameter int T_NOTA  = 50_000_000,
   parameter int T_PAUSA = 12_500_000
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        iniciar,
   input  logic                        parar,
   input  logic [LARGURA_DESAFIO-1:0]  desafio,
   input  logic [LARGURA_INDICE-1:0]   rodada,
   input  logic [LARGURA_NOTA-1:0]     nota_mem,
   output logic [LARGURA_ENDERECO-1:0] endereco,
   output logic [LARGURA_NOTA-1:0]     nota_saida,
   output logic                        nota_valida,
   output logic                        ocupado,
   output logic                        fim_reproducao
);

   localparam int C_T_MAX     = (T_NOTA > T_PAUSA) ? T_NOTA : T_PAUSA;
   localparam int C_LARG_TEMP = $clog2(C_T_MAX) + 1;
   localparam logic [C_LARG_TEMP-1:0] C_LIM_NOTA  = C_LARG_TEMP'(T_NOTA);
   localparam logic [C_LARG_TEMP-1:0] C_LIM_PAUSA = C_LARG_TEMP'(T_PAUSA);

   estado_t                    r_estado;
   estado_t                    w_prox_estado;
   logic [LARGURA_INDICE-1:0]  r_indice;
   logic [LARGURA_DESAFIO-1:0] r_desafio;
   logic [LARGURA_INDICE-1:0]  r_rodada;
   logic [LARGURA_NOTA-1:0]    r_nota;

   logic                       w_tmr_clear;
   logic                       w_tmr_en;
   logic [C_LARG_TEMP-1:0]     w_tmr_limite;
   logic                       w_fim_tempo;
   logic                       w_ultima;

   assign w_ultima   = (r_indice == r_rodada);
   assign endereco   = {r_desafio, r_indice};
   assign nota_saida = r_nota;

   temporizador_nota #(
      .LARGURA   (C_LARG_TEMP)
   ) u_temporizador (
      .clock     (clock),
      .reset     (reset),
      .clear     (w_tmr_clear),
      .enable    (w_tmr_en),
      .limit     (w_tmr_limite),
      .fim_tempo (w_fim_tempo)
   );

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado <= OCIOSO;
      end else begin
         r_estado <= w_prox_estado;
      end
   end

   // Next state and Moore outputs
   always_comb begin
      w_prox_estado  = r_estado;
      nota_valida    = 1'b0;
      ocupado        = 1'b1;
      fim_reproducao = 1'b0;
      w_tmr_clear    = 1'b1;
      w_tmr_en       = 1'b0;
      w_tmr_limite   = C_LIM_NOTA;

      case (r_estado)
         OCIOSO: begin
            ocupado = 1'b0;
            if (iniciar) begin
               w_prox_estado = CARREGA;
            end
         end
         CARREGA: begin
            w_prox_estado = TOCA;
         end
         TOCA: begin
            nota_valida = 1'b1;
            w_tmr_clear = 1'b0;
            w_tmr_en    = 1'b1;
            if (w_fim_tempo) begin
               w_prox_estado = PAUSA;
            end
         end
         PAUSA: begin
            w_tmr_clear  = 1'b0;
            w_tmr_en     = 1'b1;
            w_tmr_limite = C_LIM_PAUSA;
            if (w_fim_tempo) begin
               w_prox_estado = w_ultima ? FIM : CARREGA;
            end
         end
         FIM: begin
            fim_reproducao = 1'b1;
            w_prox_estado  = OCIOSO;
         end
         default: begin
            w_prox_estado = OCIOSO;
         end
      endcase

      // Abort overrides every transition, including a start in idle.
      if (parar) begin
         w_prox_estado = OCIOSO;
      end
   end

   // Playback context: bank/round latched at start, index and note.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_desafio <= '0;
         r_rodada  <= '0;
         r_indice  <= '0;
         r_nota    <= '0;
      end else if (!parar) begin
         if ((r_estado == OCIOSO) && iniciar) begin
            r_desafio <= desafio;
            r_rodada  <= rodada;
            r_indice  <= '0;
         end
         if (r_estado == CARREGA) begin
            r_nota <= nota_mem;
         end
         // Index stops at the last note, so it never wraps into bank 0.
         if ((r_estado == PAUSA) && w_fim_tempo && !w_ultima) begin
            r_indice <= r_indice + LARGURA_INDICE'(1);
         end
      end
   end

endmodule
`default_nettype wire
